// File: rtl/sync_glitch_filter_if.sv
// Signal bundle between a synchronized bus/control line and its glitch filter.
// The master drives the synchronized level; the slave returns filtered level, strobes and width.
interface sync_glitch_filter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             i_sync;
    logic             o_level;
    logic             o_rise;
    logic             o_fall;
    logic [CNT_W-1:0] o_high_cycles;
    logic             o_high_valid;
    logic             o_overflow;

    modport master (
        output i_sync,
        input  o_level, o_rise, o_fall, o_high_cycles, o_high_valid, o_overflow
    );

    modport slave (
        input  i_sync,
        output o_level, o_rise, o_fall, o_high_cycles, o_high_valid, o_overflow
    );
endinterface

// File: rtl/sync_glitch_filter.sv
// Glitch filter for an already-synchronized Apple II bus/control line: qualifies level
// changes over STABLE_CYCLES samples, emits rise/fall strobes and measures high-pulse width.
module sync_glitch_filter #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16,
    parameter logic        INIT          = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    sync_glitch_filter_if.slave  bus
);
    localparam int unsigned     SW        = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0]   STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WMAX     = '1;

    logic [SW-1:0]    stab_q, stab_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] hcyc_q, hcyc_d;
    logic             hval_q, hval_d;
    logic             ovf_q, ovf_d;

    logic             flip;
    logic [CNT_W-1:0] width_inc;

    assign flip      = (bus.i_sync != level_q) && (stab_q == STAB_LAST);
    assign width_inc = (width_q == WMAX) ? WMAX : width_q + 1'b1;

    always_comb begin
        stab_d  = stab_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        width_d = width_q;
        hcyc_d  = hcyc_q;
        hval_d  = 1'b0;
        ovf_d   = ovf_q;

        if (bus.i_sync == level_q) begin
            stab_d = '0;
        end else if (flip) begin
            stab_d  = '0;
            level_d = ~level_q;
        end else begin
            stab_d = stab_q + 1'b1;
        end

        if (flip && !level_q) begin
            rise_d  = 1'b1;
            width_d = '0;
        end else if (flip && level_q) begin
            fall_d  = 1'b1;
            hval_d  = 1'b1;
            hcyc_d  = width_inc;
            // A pulse whose final count lands on the maximum is flagged as saturated too.
            ovf_d   = (width_q == WMAX) || (width_q == WMAX - 1'b1);
            width_d = '0;
        end else if (level_q) begin
            width_d = width_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stab_q  <= '0;
            level_q <= INIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            width_q <= '0;
            hcyc_q  <= '0;
            hval_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            stab_q  <= stab_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            width_q <= width_d;
            hcyc_q  <= hcyc_d;
            hval_q  <= hval_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.o_level       = level_q;
    assign bus.o_rise        = rise_q;
    assign bus.o_fall        = fall_q;
    assign bus.o_high_cycles = hcyc_q;
    assign bus.o_high_valid  = hval_q;
    assign bus.o_overflow    = ovf_q;
endmodule

// File: doc/sync_glitch_filter.md
Name: sync_glitch_filter

Overview:
- Sits directly downstream of the 3-flop input synchronizer.
- Consumes that synchronizer's already-synchronized level (its `o` output) from an Apple II bus or control line.
- Rejects glitches shorter than a programmable number of clk cycles and emits a clean level plus single-cycle rise/fall strobes.
- Measures the width of each accepted high pulse in clk cycles, for bus-timing diagnostics and soft-switch pulse decoding.

Parameters:
- STABLE_CYCLES, 4: consecutive differing samples required before the output level flips. Legal range 1..255.
- CNT_W, 16: width of the high-pulse width counter and result.
- INIT, 1'b0: value of o_level after reset.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- i_sync  in  1  synchronized input level; must already be in the clk domain.
- o_level  out  1  filtered level.
- o_rise  out  1  one-cycle strobe, high in the first cycle o_level is 1.
- o_fall  out  1  one-cycle strobe, high in the first cycle o_level is 0.
- o_high_cycles  out  CNT_W  number of cycles o_level was 1 in the most recently completed high pulse; held until the next completion.
- o_high_valid  out  1  one-cycle strobe, coincident with o_fall, when o_high_cycles updates.
- o_overflow  out  1  updated with o_high_valid; 1 if the completed pulse saturated the counter.

Behaviour:
- Reset is synchronous and active-high; a single clock, clk.
- Reset values while rst=1 at a posedge:
  - o_level=INIT.
  - o_rise, o_fall, o_high_valid, o_overflow = 0.
  - o_high_cycles = 0.
  - Internal stability counter = 0; internal width counter = 0.
- Reset mid-pulse abandons any measurement in progress; no strobe is emitted.
- Stability counter: width is clog2(STABLE_CYCLES+1).
  - At each posedge where i_sync != o_level, it increments.
  - At each posedge where i_sync == o_level, it clears to 0.
  - A single matching sample therefore restarts the qualification.
- Flip: at the posedge where the counter would reach STABLE_CYCLES:
  - o_level <= ~o_level and the counter clears to 0.
  - Latency: exactly STABLE_CYCLES consecutive differing samples, so o_level changes on the STABLE_CYCLES-th edge that sampled the new value.
  - STABLE_CYCLES=1 degenerates to a single register delay.
- Strobes:
  - o_rise and o_fall are registered and asserted on the same edge that o_level flips.
  - Each lasts exactly one cycle.
  - They are never both high in the same cycle.
  - Back-to-back flips are impossible for STABLE_CYCLES >= 2. With STABLE_CYCLES=1, alternating input yields alternating strobes every cycle, which is legal.
- Width counter (saturating at 2^CNT_W-1):
  - On the rise edge it loads 0.
  - On each edge with o_level=1 and no fall, it saturating-increments.
  - On the fall edge:
    - o_high_cycles <= sat(counter+1), o_high_valid=1.
    - o_overflow=1 iff counter+1 saturated (counter already at max, or counter+1 = max). Otherwise o_overflow=0.
  - The result is the count of cycles o_level was 1, including the rise cycle.
- If INIT=1, the width counter starts counting from reset release. The first fall reports cycles since reset.
- Qualification and measurement share no state: a glitch during a high pulse that is rejected does not disturb the width count.

Test Plan (STABLE_CYCLES=4, CNT_W=8, INIT=0 unless noted):
- Reset: hold rst 3 cycles with i_sync toggling -> all outputs 0, o_level=0; after release with i_sync=0 -> no strobes.
- Glitch rejection: i_sync high for 3 cycles then low -> o_level stays 0, no o_rise. Repeat with 3-high, 1-low, 3-high -> still no rise, because the counter restarts.
- Clean pulse: i_sync 0->1 held 20 cycles then 0:
  - o_rise on the 4th edge sampling 1.
  - o_fall and o_high_valid on the 4th edge sampling 0.
  - o_high_cycles=20, o_overflow=0.
  - o_high_cycles holds 20 afterwards.
- Saturation: i_sync high 300 cycles -> on fall, o_high_cycles=255, o_overflow=1. Next 10-cycle pulse -> 10, o_overflow=0.
- Mid-pulse glitch and reset: 2-cycle low glitch inside a 50-cycle high -> no fall, reported width 50. Then assert rst mid-pulse -> o_level=0, no o_fall/o_high_valid, o_high_cycles=0.
- STABLE_CYCLES=1, INIT=1:
  - Reset -> o_level=1.
  - i_sync alternating 0/1 -> o_level follows one cycle later with alternating o_fall/o_rise.
  - o_high_cycles=1 per pulse, except the first pulse, which counts from reset.
